axi2mem_wr_channel_mb: RTL

// Parametrised AXI write channel to TCDM command and data queues. Generalises the 2-lane/64-bit

---
 rtl/axi2mem_wr_channel_mb_if.sv | 56 +++++
 rtl/axi2mem_wr_channel_mb.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/axi2mem_wr_channel_mb_if.sv
// AXI4 write-side slave bundle (AW, W, B) for axi2mem_wr_channel_mb.
// The slave modport is the channel's view; the master modport drives it.
interface axi2mem_wr_channel_mb_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int AXI_USER_WIDTH = 6
);
    logic                          aw_valid;
    logic                          aw_ready;
    logic [AXI_ADDR_WIDTH-1:0]     aw_addr;
    logic [7:0]                    aw_len;
    logic [2:0]                    aw_size;
    logic [1:0]                    aw_burst;
    logic                          aw_lock;
    logic [3:0]                    aw_cache;
    logic [2:0]                    aw_prot;
    logic [3:0]                    aw_region;
    logic [3:0]                    aw_qos;
    logic [5:0]                    aw_atop;
    logic [AXI_ID_WIDTH-1:0]       aw_id;
    logic [AXI_USER_WIDTH-1:0]     aw_user;

    logic                          w_valid;
    logic                          w_ready;
    logic [AXI_DATA_WIDTH-1:0]     w_data;
    logic [AXI_DATA_WIDTH/8-1:0]   w_strb;
    logic                          w_last;
    logic [AXI_USER_WIDTH-1:0]     w_user;

    logic                          b_valid;
    logic                          b_ready;
    logic [1:0]                    b_resp;
    logic [AXI_ID_WIDTH-1:0]       b_id;
    logic [AXI_USER_WIDTH-1:0]     b_user;

    modport slave (
        input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_region, aw_qos, aw_atop, aw_id, aw_user,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last, w_user,
        output w_ready,
        output b_valid, b_resp, b_id, b_user,
        input  b_ready
    );

    modport master (
        output aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_region, aw_qos, aw_atop, aw_id, aw_user,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last, w_user,
        input  w_ready,
        input  b_valid, b_resp, b_id, b_user,
        output b_ready
    );
endinterface

// File: rtl/axi2mem_wr_channel_mb.sv
// AXI write channel to per-lane TCDM command/data queues; B returned in AW order via an ID FIFO.
// Optional AXI2MEM_WR_ERR_RESP_EN: WRAP / 4 KiB-crossing INCR bursts are drained and answered SLVERR.
module axi2mem_wr_channel_mb #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int AXI_USER_WIDTH = 6,
    parameter int ID_FIFO_DEPTH  = 4,
    parameter int NB_LANES       = AXI_DATA_WIDTH/32
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          test_en_i,
    axi2mem_wr_channel_mb_if.slave                        axi_slave,
    output logic [NB_LANES-1:0][AXI_ID_WIDTH-1:0]         trans_id_o,
    output logic [NB_LANES-1:0][AXI_ADDR_WIDTH-1:0]       trans_add_o,
    output logic [NB_LANES-1:0]                           trans_last_o,
    output logic [NB_LANES-1:0]                           trans_req_o,
    input  logic [NB_LANES-1:0]                           trans_gnt_i,
    input  logic                                          trans_r_req_i,
    input  logic [AXI_ID_WIDTH-1:0]                       trans_r_id_i,
    output logic                                          trans_r_gnt_o,
    output logic [AXI_DATA_WIDTH-1:0]                     data_dat_o,
    output logic [AXI_DATA_WIDTH/8-1:0]                   data_strb_o,
    output logic                                          data_req_o,
    input  logic                                          data_gnt_i
);
    localparam int BYTES = AXI_DATA_WIDTH/8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int PTR_W = (ID_FIFO_DEPTH > 1) ? $clog2(ID_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(ID_FIFO_DEPTH + 1);
`ifdef AXI2MEM_WR_ERR_RESP_EN
    localparam int ENT_W = AXI_ID_WIDTH + 1;
`else
    localparam int ENT_W = AXI_ID_WIDTH;
`endif
    localparam logic [AXI_ADDR_WIDTH-1:0] STEP = AXI_ADDR_WIDTH'(BYTES);

    typedef enum logic {IDLE, RUN} state_e;

    state_e                    state_q;
    logic [7:0]                cnt_q, len_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [1:0]                burst_q;
    logic [ENT_W-1:0]          fifo_q [ID_FIFO_DEPTH];
    logic [PTR_W-1:0]          rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]          count_q;

    logic                      idle_s, fire_s, push_s, pop_s, beat_err_s, err_live_s;
    logic                      fifo_full_s, fifo_empty_s, head_err_s;
    logic [AXI_ADDR_WIDTH-1:0] base_s, beat_addr_s;
    logic [ENT_W-1:0]          head_s, push_ent_s;
    logic                      unused_s;

    assign idle_s       = (state_q == IDLE);
    assign base_s       = {axi_slave.aw_addr[AXI_ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
    assign fifo_full_s  = (count_q == CNT_W'(ID_FIFO_DEPTH));
    assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
    assign head_s       = fifo_q[rd_ptr_q];

`ifdef AXI2MEM_WR_ERR_RESP_EN
    logic        err_q;
    logic [31:0] end_s;
    // Burst is flagged when WRAP or when an INCR burst runs past the end of its 4 KiB page.
    always_comb begin
        end_s      = 32'(base_s[11:0]) + (32'(axi_slave.aw_len) + 32'd1) * 32'(BYTES);
        err_live_s = (axi_slave.aw_burst == 2'b10) |
                     ((axi_slave.aw_burst != 2'b00) & (end_s > 32'd4096));
    end
    assign beat_err_s = idle_s ? err_live_s : err_q;
    assign push_ent_s = {axi_slave.aw_id, err_live_s};
    assign head_err_s = head_s[0];
    assign axi_slave.b_id = head_s[ENT_W-1:1];
`else
    assign err_live_s = 1'b0;
    assign beat_err_s = 1'b0;
    assign push_ent_s = axi_slave.aw_id;
    assign head_err_s = 1'b0;
    assign axi_slave.b_id = head_s;
`endif

    // A beat moves only when every lane queue and the data queue can take it (drained beats need no space).
    always_comb begin
        fire_s = axi_slave.w_valid & (beat_err_s | ((&trans_gnt_i) & data_gnt_i));
        if (idle_s) begin
            fire_s      = fire_s & axi_slave.aw_valid & ~fifo_full_s;
            beat_addr_s = base_s;
        end else begin
            beat_addr_s = addr_q;
        end
    end

    assign push_s = fire_s & idle_s;
    assign pop_s  = axi_slave.b_valid & axi_slave.b_ready;

    // Per-lane command fan-out; every lane carries the same beat, offset by 4 bytes per lane.
    always_comb begin
        for (int i = 0; i < NB_LANES; i++) begin
            trans_add_o[i] = beat_addr_s + AXI_ADDR_WIDTH'(4*i);
            trans_id_o[i]  = idle_s ? axi_slave.aw_id : id_q;
        end
        trans_req_o  = {NB_LANES{fire_s & ~beat_err_s}};
        trans_last_o = {NB_LANES{fire_s & (idle_s ? (axi_slave.aw_len == 8'd0) : (cnt_q == len_q))}};
    end

    assign axi_slave.aw_ready = push_s;
    assign axi_slave.w_ready  = fire_s;
    assign data_req_o         = fire_s & ~beat_err_s;
    assign data_dat_o         = axi_slave.w_data;
    assign data_strb_o        = axi_slave.w_strb;

    assign axi_slave.b_valid  = ~fifo_empty_s & (trans_r_req_i | head_err_s);
    assign axi_slave.b_resp   = head_err_s ? 2'b10 : 2'b00;
    assign axi_slave.b_user   = {AXI_USER_WIDTH{1'b0}};
    assign trans_r_gnt_o      = axi_slave.b_ready & ~fifo_empty_s & ~head_err_s;

    // Burst sequencer: IDLE accepts AW with the first beat, RUN counts the remaining beats.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            len_q   <= 8'd0;
            addr_q  <= {AXI_ADDR_WIDTH{1'b0}};
            id_q    <= {AXI_ID_WIDTH{1'b0}};
            burst_q <= 2'b00;
`ifdef AXI2MEM_WR_ERR_RESP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (fire_s && (axi_slave.aw_len != 8'd0)) begin
                        state_q <= RUN;
                        cnt_q   <= 8'd1;
                        len_q   <= axi_slave.aw_len;
                        id_q    <= axi_slave.aw_id;
                        burst_q <= axi_slave.aw_burst;
                        addr_q  <= (axi_slave.aw_burst == 2'b00) ? base_s : base_s + STEP;
`ifdef AXI2MEM_WR_ERR_RESP_EN
                        err_q   <= err_live_s;
`endif
                    end
                end
                RUN: begin
                    if (fire_s) begin
                        addr_q <= (burst_q == 2'b00) ? addr_q : addr_q + STEP;
                        if (cnt_q == len_q) begin
                            state_q <= IDLE;
                            cnt_q   <= 8'd0;
                        end else begin
                            cnt_q   <= cnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outstanding-burst FIFO; a full FIFO refuses the push even when a pop happens in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < ID_FIFO_DEPTH; i++) begin
                fifo_q[i] <= {ENT_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_q[wr_ptr_q] <= push_ent_s;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(ID_FIFO_DEPTH-1)) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(ID_FIFO_DEPTH-1)) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    assign unused_s = ^{test_en_i, trans_r_id_i, err_live_s, axi_slave.aw_addr[OFFS-1:0],
                        axi_slave.aw_size, axi_slave.aw_lock, axi_slave.aw_cache, axi_slave.aw_prot,
                        axi_slave.aw_region, axi_slave.aw_qos, axi_slave.aw_atop, axi_slave.aw_user,
                        axi_slave.w_last, axi_slave.w_user};
endmodule
